seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexing scan controller that shares one seven-segment bus, built on the team's `seg7` decoder, among `NUM_DIGITS` common-cathode digits. It holds a per-digit value register file, which a write handshake loads through shadow registers. Staged writes commit atomically at frame boundaries, so the display never shows a torn multi-digit value. Each digit gets a fixed dwell slot consisting of an anti-ghosting blank interval followed by a PWM-dimmed display interval. The block sits between the counting logic, for example a multi-digit seconds counter, and the chip's `io_out` pins.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of digits scanned, range 2..8.
- `DWELL`, default 250: clocks per digit slot, minimum `BLANK`+16.
- `BLANK`, default 8: blank clocks at the start of each slot, minimum 1.

Ports:
- `clk`, in, 1 bit: clock.
- `reset`, in, 1 bit: synchronous, active-high.
- `enable`, in, 1 bit: scanning enabled.
- `wr_valid`, in, 1 bit: write request.
- `wr_ready`, out, 1 bit: write accepted when `wr_valid` and `wr_ready` are both high at a rising edge.
- `wr_addr`, in, `$clog2(NUM_DIGITS)` bits: digit index. An index of `NUM_DIGITS` or above is accepted and discarded.
- `wr_data`, in, 4 bits: digit value, fed to `seg7`.
- `wr_dp`, in, 1 bit: decimal point for that digit.
- `brightness`, in, 4 bits: PWM duty, sampled every cycle.
- `seg_out`, out, 7 bits: segment lines, active high.
- `dp_out`, out, 1 bit: decimal point line.
- `digit_sel`, out, `NUM_DIGITS` bits: one-hot or zero digit enable, active high.
- `frame_start`, out, 1 bit: one-cycle pulse at the start of each frame.

## Operation
- Storage: shadow file and active file, each holding `NUM_DIGITS` × (4-bit value, dp). An accepted write updates only the shadow entry.
- Commit: the whole shadow file is copied to the active file at the edge ending the last cycle of a frame.
  - `wr_ready` is 0 in exactly that cycle and 1 in every other cycle, including while `enable` is low.
- Frame position: while `enable` is high, a phase counter `p` runs from 0 to `NUM_DIGITS*DWELL-1` and then wraps to 0.
  - Digit index `d = p / DWELL`.
  - Slot position `s = p mod DWELL`.
- State machine with three states:
  - IDLE: entered on reset or when `enable` is low.
  - BLANK: `s < BLANK`.
  - SHOW: `s >= BLANK`.
  - Transitions:
    - IDLE→BLANK, with `p=0`, on the first cycle `enable` is high.
    - BLANK→SHOW when `s` reaches `BLANK`.
    - SHOW→BLANK at the slot boundary.
    - Any state→IDLE when `enable` is low.
- PWM: a 4-bit counter `q = (s-BLANK) mod 16`, cleared on every SHOW entry. The digit is lit when `q < brightness`.
  - `brightness` 0 keeps the digit permanently dark.
  - `brightness` 15 gives 15/16 duty.
- Outputs during SHOW when lit:
  - `digit_sel` = one-hot(`d`).
  - `seg_out` = `seg7`(active value[`d`]).
  - `dp_out` = active dp[`d`].
- Outputs in all other cases (BLANK, IDLE, unlit SHOW): `digit_sel`, `seg_out` and `dp_out` are all 0.
- `frame_start` = 1 exactly in the cycle where `p=0`, only while `enable` is high.
- Enable dropped mid-frame: `p` is cleared. No commit happens, and pending shadow writes are held until the next completed frame.

## Timing
- All outputs are registered. Output values in cycle `t` are a function of the state and counters in cycle `t-1`, giving one cycle of latency.
  - `frame_start` therefore appears one cycle after `p=0`, aligned with the first BLANK output cycle of digit 0.
- Reset values:
  - `seg_out`, `dp_out`, `digit_sel`, `frame_start` = 0.
  - `wr_ready` = 1.
  - `p` = 0; all counters = 0.
  - All shadow and active entries = value 0, dp 0.
  - State = IDLE.
- Reset has priority over everything: asserting it mid-frame blanks the outputs on the next edge and discards staged writes.
- Write arriving in the commit cycle: `wr_ready`=0, so it stalls and is accepted one cycle later, into the next frame's shadow file.
- Repeated writes to the same address within one frame: the last accepted write wins.
- `brightness` changes take effect on the next cycle. No glitch protection is required beyond the registered outputs.
- Counter widths:
  - `p`: `$clog2(NUM_DIGITS*DWELL)` bits.
  - `s`: `$clog2(DWELL)` bits.
  - No overflow is permitted at the parameter limits.

## Test plan
(All scenarios use `NUM_DIGITS`=4, `DWELL`=40, `BLANK`=4.)
- Reset, then `enable`=1, `brightness`=15, no writes. Required:
  - `frame_start` pulses every 160 cycles.
  - `digit_sel` sequences 0001→0010→0100→1000.
  - Each digit is dark for the first 4 cycles of its slot.
  - `seg_out` = `seg7`(0) in lit cycles.
- Write values 1, 2, 3, 4 to addresses 0–3 mid-frame. Required:
  - The current frame still shows 0 on all digits.
  - The next frame shows 1, 2, 3, 4.
  - `wr_ready` is low only in cycle `p`=159.
- Hold `wr_valid`=1 (addr 2, value 9, dp 1) across the commit cycle. Required:
  - Stalled for exactly 1 cycle.
  - Digit 2 shows `seg7`(9) with `dp_out`=1 starting two frames later.
- Vary `brightness` 0, 1, 8, 15 with a fixed display. Required: lit cycles per 16-cycle PWM period of 0, 1, 8, 15 respectively; never any lit cycle in BLANK.
- Drop `enable` at `p`=70 and raise it again 10 cycles later. Required:
  - Outputs are 0 one cycle after the drop.
  - The restart begins at digit 0 with a `frame_start` pulse.
  - No commit occurs for the interrupted frame.
- Assert `reset` during digit 2 SHOW. Required: all outputs 0 on the next cycle, `wr_ready`=1, and the display shows 0 after restart.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS common-cathode
// seven-segment digits sharing one segment bus.
//
// Writes land in a shadow register file and are copied into the displayed
// (active) file at the last cycle of a frame. This keeps a multi-digit value
// from appearing half-updated. Each digit slot is DWELL clocks long. The first
// BLANK clocks are dark, which prevents ghosting while the digit select
// switches. The remaining clocks are PWM-dimmed by 'brightness'.
//
// Segment bit order on seg_out: bit 0 = a, 1 = b, 2 = c, 3 = d, 4 = e,
// 5 = f, 6 = g. Every output is high when active.

module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 250,
    parameter int BLANK      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [3:0]                    wr_data,
    input  logic                          wr_dp,
    input  logic [3:0]                    brightness,
    output logic [6:0]                    seg_out,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          frame_start
);

    // ------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------
    localparam int AW    = $clog2(NUM_DIGITS);
    localparam int FRAME = NUM_DIGITS * DWELL;
    localparam int PW    = $clog2(FRAME);
    localparam int SW    = $clog2(DWELL);

    localparam logic [PW-1:0] P_LAST   = PW'(FRAME - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(DWELL - 1);
    localparam logic [SW-1:0] S_SHOW   = SW'(BLANK);
    localparam logic [AW-1:0] D_LAST   = AW'(NUM_DIGITS - 1);
    localparam logic [AW:0]   ADDR_LIM = (AW + 1)'(NUM_DIGITS);

    // Scan state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    // One digit entry: hex value plus decimal point
    typedef struct packed {
        logic [3:0] value;
        logic       dp;
    } digit_t;

    // ------------------------------------------------------------------
    // Hex to seven-segment decoder (bit 0 = a ... bit 6 = g)
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]            state_q, state_d;
    logic [PW-1:0]         p_q, p_d;        // frame phase
    logic [SW-1:0]         s_q, s_d;        // position inside the digit slot
    logic [AW-1:0]         d_q, d_d;        // digit index being scanned
    logic [3:0]            q_q, q_d;        // PWM phase inside SHOW

    digit_t                shadow_q [NUM_DIGITS];
    digit_t                active_q [NUM_DIGITS];

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  fs_q, fs_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [1:0] cur_state;
    logic       s_wrap;
    logic       p_wrap;
    logic       commit;
    logic       lit;
    logic       wr_fire;

    // Effective state of this cycle: IDLE while disabled. The first enabled
    // cycle after IDLE acts as BLANK at p = 0.
    // NOTE: every variable assigned in an always_comb gets a default at the top, so no path can leave it unassigned and infer a latch.
    always_comb begin
        cur_state = ST_IDLE;
        if (enable) begin
            case (state_q)
                ST_SHOW: cur_state = ST_SHOW;
                default: cur_state = ST_BLANK;
            endcase
        end
    end

    // Phase counters, next state and the commit / handshake decision
    always_comb begin
        s_wrap  = (s_q == S_LAST);
        p_wrap  = (p_q == P_LAST);
        commit  = enable && p_wrap;

        s_d     = s_wrap ? '0 : s_q + 1'b1;
        p_d     = p_wrap ? '0 : p_q + 1'b1;
        d_d     = d_q;
        if (s_wrap) begin
            d_d = (d_q == D_LAST) ? '0 : d_q + 1'b1;
        end

        case (cur_state)
            ST_BLANK: state_d = (s_d == S_SHOW) ? ST_SHOW : ST_BLANK;
            ST_SHOW:  state_d = s_wrap ? ST_BLANK : ST_SHOW;
            default:  state_d = ST_IDLE;
        endcase

        // The PWM phase restarts from 0 on every SHOW entry.
        q_d = (cur_state == ST_SHOW) ? q_q + 1'b1 : 4'd0;

        // Dropping enable restarts the frame from the beginning.
        if (!enable) begin
            s_d     = '0;
            p_d     = '0;
            d_d     = '0;
            q_d     = 4'd0;
            state_d = ST_IDLE;
        end
    end

    // Handshake: the only busy cycle is the commit cycle, so a write can never
    // race the shadow-to-active copy. This path is combinational from
    // 'enable', because an interrupted last cycle does not commit.
    assign wr_ready = ~commit;
    assign wr_fire  = wr_valid && wr_ready && ({1'b0, wr_addr} < ADDR_LIM);

    // Next output values, computed from this cycle's state and counters
    always_comb begin
        lit   = (cur_state == ST_SHOW) && (q_q < brightness);
        sel_d = '0;
        seg_d = 7'h00;
        dp_d  = 1'b0;
        if (lit) begin
            sel_d = NUM_DIGITS'(1) << d_q;
            seg_d = seg7(active_q[d_q].value);
            dp_d  = active_q[d_q].dp;
        end
        fs_d  = enable && (p_q == '0);
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Scan FSM and counters; reset is synchronous and overrides everything
    // NOTE: sequential state uses non-blocking assignments so every register samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            s_q     <= '0;
            d_q     <= '0;
            q_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            s_q     <= s_d;
            d_q     <= d_d;
            q_q     <= q_d;
        end
    end

    // Shadow file: accepted writes stage here until the next frame commit
    // NOTE: both register files are reset on purpose, so a reset discards staged writes and the display restarts from all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (wr_fire) begin
            shadow_q[wr_addr] <= '{value: wr_data, dp: wr_dp};
        end
    end

    // Active file: the whole shadow file is copied in at the last frame cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_q[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // Output registers: one cycle of latency from the scan position
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= 7'h00;
            dp_q  <= 1'b0;
            sel_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            sel_q <= sel_d;
            fs_q  <= fs_d;
        end
    end

    assign seg_out     = seg_q;
    assign dp_out      = dp_q;
    assign digit_sel   = sel_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized and directed stimulus for seg7_scan_ctrl. It is
// checked against a frame-position reference model that works from the
// consecutive-enabled-cycle count, using plain division and modulo.

module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int DW    = 40;
    localparam int BL    = 4;
    localparam int TOTAL = N * DW;
    localparam int AW    = $clog2(N);

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          enable     = 1'b0;
    logic          wr_valid   = 1'b0;
    logic [AW-1:0] wr_addr    = '0;
    logic [3:0]    wr_data    = 4'd0;
    logic          wr_dp      = 1'b0;
    logic [3:0]    brightness = 4'd0;
    logic          wr_ready;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [N-1:0]  digit_sel;
    logic          frame_start;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS(N),
        .DWELL     (DW),
        .BLANK     (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .brightness (brightness),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .digit_sel  (digit_sel),
        .frame_start(frame_start)
    );

    // Reference hex patterns, bit 0 = a ... bit 6 = g
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    int         pos;                      // frame position of the cycle about to be driven
    logic [3:0] sh_val [N];
    logic       sh_dp  [N];
    logic [3:0] ac_val [N];
    logic       ac_dp  [N];
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [N-1:0] exp_sel;
    logic       exp_fs;

    int vectors     = 0;
    int miscompares = 0;
    int lit_cnt     = 0;
    bit last_acc    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !(enable && (pos == TOTAL - 1));
    endfunction

    task automatic model_clear();
        pos = 0;
        for (int i = 0; i < N; i++) begin
            sh_val[i] = 4'd0;
            sh_dp[i]  = 1'b0;
            ac_val[i] = 4'd0;
            ac_dp[i]  = 1'b0;
        end
        exp_seg = 7'h00;
        exp_dp  = 1'b0;
        exp_sel = '0;
        exp_fs  = 1'b0;
    endtask

    // Advance the model across one rising edge, using the inputs now applied
    task automatic model_edge();
        int d;
        int s;
        bit lit;
        lit = 1'b0;
        if (reset) begin
            model_clear();
            return;
        end
        exp_seg = 7'h00;
        exp_dp  = 1'b0;
        exp_sel = '0;
        exp_fs  = 1'b0;
        if (enable) begin
            d      = pos / DW;
            s      = pos % DW;
            lit    = (s >= BL) && (((s - BL) % 16) < int'(brightness));
            exp_fs = (pos == 0);
            if (lit) begin
                exp_sel = N'(1) << d;
                exp_seg = seg_tab[ac_val[d]];
                exp_dp  = ac_dp[d];
            end
        end
        if (wr_valid && model_ready() && (int'(wr_addr) < N)) begin
            sh_val[wr_addr] = wr_data;
            sh_dp[wr_addr]  = wr_dp;
        end
        if (enable && (pos == TOTAL - 1)) begin
            for (int i = 0; i < N; i++) begin
                ac_val[i] = sh_val[i];
                ac_dp[i]  = sh_dp[i];
            end
        end
        pos = enable ? (pos + 1) % TOTAL : 0;
    endtask

    // One clock: compare registered outputs, apply inputs, compare wr_ready
    task automatic cycle(input bit rst, input bit en, input bit wv, input logic [AW-1:0] a,
                         input logic [3:0] dat, input bit dpv, input logic [3:0] br);
        @(negedge clk);
        check("seg_out",     32'(seg_out),     32'(exp_seg));
        check("dp_out",      32'(dp_out),      32'(exp_dp));
        check("digit_sel",   32'(digit_sel),   32'(exp_sel));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        lit_cnt   += int'(digit_sel != '0);
        reset      = rst;
        enable     = en;
        wr_valid   = wv;
        wr_addr    = a;
        wr_data    = dat;
        wr_dp      = dpv;
        brightness = br;
        #1;
        check("wr_ready", 32'(wr_ready), 32'(model_ready()));
        last_acc = wv && wr_ready && !rst;
        model_edge();
    endtask

    task automatic run(input int n, input bit en, input logic [3:0] br);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, en, 1'b0, '0, 4'd0, 1'b0, br);
        end
    endtask

    // Run enabled until the next driven cycle sits at frame position 'target'
    task automatic align(input int target, input logic [3:0] br);
        for (int i = 0; i < 2 * TOTAL && pos != target; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0, 4'd0, 1'b0, br);
        end
        if (pos != target) check("align", 32'(pos), 32'(target));
    endtask

    initial begin
        int stalls;
        int b;
        logic [3:0] br;
        int bright_list [4] = '{0, 1, 8, 15};

        model_clear();
        repeat (2) @(posedge clk);

        // Reset state, then an idle disabled cycle
        cycle(1'b1, 1'b0, 1'b0, '0, 4'd0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, '0, 4'd0, 1'b0, 4'd15);

        // Free-running scan, full brightness, no writes
        run(2 * TOTAL + 5, 1'b1, 4'd15);

        // Mid-frame writes 1..4 to digits 0..3, shown from the next frame
        align(50, 4'd15);
        for (int a = 0; a < N; a++) begin
            cycle(1'b0, 1'b1, 1'b1, AW'(a), 4'(a + 1), 1'b0, 4'd15);
        end
        run(2 * TOTAL, 1'b1, 4'd15);

        // Write held across the commit cycle stalls exactly one cycle
        align(TOTAL - 1, 4'd15);
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, AW'(2), 4'd9, 1'b1, 4'd15);
            if (last_acc) break;
            stalls++;
        end
        check("stall_cycles", 32'(stalls), 32'd1);
        run(3 * TOTAL, 1'b1, 4'd15);

        // Brightness sweep: lit cycles per frame = digits * (2*b + min(b,4))
        foreach (bright_list[k]) begin
            b  = bright_list[k];
            br = 4'(b);
            align(0, br);
            run(TOTAL, 1'b1, br);
            lit_cnt = 0;
            run(TOTAL, 1'b1, br);
            check("lit_per_frame", 32'(lit_cnt), 32'(N * (2 * b + ((b < 4) ? b : 4))));
        end

        // Enable dropped at p=70 for 10 cycles with a write pending
        align(20, 4'd15);
        cycle(1'b0, 1'b1, 1'b1, AW'(1), 4'd7, 1'b1, 4'd15);
        align(70, 4'd15);
        run(10, 1'b0, 4'd15);
        run(2 * TOTAL, 1'b1, 4'd15);

        // Reset during digit 2 SHOW with a write pending
        align(30, 4'd15);
        cycle(1'b0, 1'b1, 1'b1, AW'(3), 4'd5, 1'b1, 4'd15);
        align(2 * DW + 10, 4'd15);
        cycle(1'b1, 1'b1, 1'b0, '0, 4'd0, 1'b0, 4'd15);
        run(2 * TOTAL, 1'b1, 4'd15);

        // Randomized traffic
        br = 4'd15;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) br = 4'($urandom_range(15));
            cycle($urandom_range(499) == 0,
                  $urandom_range(99) < 97,
                  $urandom_range(9) < 3,
                  AW'($urandom_range(N - 1)),
                  4'($urandom_range(15)),
                  1'($urandom_range(1)),
                  br);
        end
        run(TOTAL + 2, 1'b1, br);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
